rc4_keystream_gen: RTL and testbench

RC4_KEYSTREAM_GEN -- requirements
Module: rc4_keystream_gen

---
 rtl/rc4_keystream_gen_if.sv | 30 +++
 rtl/rc4_keystream_gen.sv | 188 ++++++++++++++++++
 tb/tb_rc4_keystream_gen.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_keystream_gen_if.sv
// Handshake bundle for the RC4 keystream generator: password loading,
// keystream requests and the registered keystream output.
interface rc4_keystream_gen_if;
    logic [7:0] password_input;  // one password byte, qualified by key_valid
    logic       key_valid;       // password byte strobe
    logic       valid;           // request for the next keystream byte
    logic [7:0] K;               // registered keystream byte
    logic       output_ready;    // one-cycle pulse marking K valid
    logic       init_done;       // key scheduling finished, sticky until reset

    // The requester drives password bytes and byte requests.
    modport master (
        output password_input,
        output key_valid,
        output valid,
        input  K,
        input  output_ready,
        input  init_done
    );

    // The generator consumes requests and returns keystream.
    modport slave (
        input  password_input,
        input  key_valid,
        input  valid,
        output K,
        output output_ready,
        output init_done
    );
endinterface

// File: rtl/rc4_keystream_gen.sv
// RC4 keystream generator.
// Flow: LOAD_KEY collects KEY_LEN password bytes, KSA runs the 256-step key
// schedule (one swap per cycle), PRGA emits one keystream byte per cycle in
// which valid is high, registered so K appears one cycle after the request.
// KEY_LEN must lie in 1..256.
module rc4_keystream_gen #(
    parameter int KEY_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    rc4_keystream_gen_if.slave bus
);

    localparam int                KIDX_W    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_LEN - 1);

    typedef enum logic [1:0] {
        LOAD_KEY,
        KSA,
        PRGA
    } state_t;

    // Architectural state
    state_t            state_q, state_d;
    logic [7:0]        s_q   [256];
    logic [7:0]        key_q [KEY_LEN];
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [KIDX_W-1:0] kc_q, kc_d;      // key load count, then key index during KSA
    logic [7:0]        k_q, k_d;
    logic              ready_q, ready_d;
    logic              init_done_q, init_done_d;

    // Array write controls produced by the FSM
    logic              load_en;
    logic              swap_en;
    logic [7:0]        swap_a, swap_b;
    logic [7:0]        swap_va, swap_vb;

    // KSA step operands
    logic [7:0]        ksa_si, ksa_j, ksa_sj;

    // PRGA step operands
    logic [7:0]        prga_i, prga_si, prga_j, prga_sj, prga_t, prga_k;

    // Table lookups for one KSA step and one PRGA step from the current state.
    always_comb begin
        ksa_si  = s_q[i_q];
        ksa_j   = j_q + ksa_si + key_q[kc_q];
        ksa_sj  = s_q[ksa_j];

        prga_i  = i_q + 8'd1;
        prga_si = s_q[prga_i];
        prga_j  = j_q + prga_si;
        prga_sj = s_q[prga_j];
        prga_t  = prga_si + prga_sj;

        // The output byte is read from the post-swap table, so the two
        // swapped locations are forwarded rather than read from s_q. When
        // i' == j' both forwarded values equal S[i'], matching the no-op swap.
        if (prga_t == prga_i) begin
            prga_k = prga_sj;
        end else if (prga_t == prga_j) begin
            prga_k = prga_si;
        end else begin
            prga_k = s_q[prga_t];
        end
    end

    // Next-state, index updates and array write controls for each phase.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so no path leaves one unassigned and infers a latch.
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        kc_d        = kc_q;
        k_d         = k_q;
        ready_d     = 1'b0;
        init_done_d = init_done_q;
        load_en     = 1'b0;
        swap_en     = 1'b0;
        swap_a      = i_q;
        swap_b      = i_q;
        swap_va     = 8'h00;
        swap_vb     = 8'h00;

        unique case (state_q)
            LOAD_KEY: begin
                if (bus.key_valid) begin
                    load_en = 1'b1;
                    if (kc_q == KIDX_LAST) begin
                        kc_d    = '0;
                        i_d     = 8'h00;
                        j_d     = 8'h00;
                        state_d = KSA;
                    end else begin
                        kc_d = kc_q + 1'b1;
                    end
                end
            end

            KSA: begin
                swap_en = 1'b1;
                swap_a  = i_q;
                swap_va = ksa_sj;
                swap_b  = ksa_j;
                swap_vb = ksa_si;
                kc_d    = (kc_q == KIDX_LAST) ? '0 : kc_q + 1'b1;
                if (i_q == 8'hFF) begin
                    i_d         = 8'h00;
                    j_d         = 8'h00;
                    init_done_d = 1'b1;
                    state_d     = PRGA;
                end else begin
                    i_d = i_q + 8'd1;
                    j_d = ksa_j;
                end
            end

            PRGA: begin
                if (bus.valid) begin
                    swap_en = 1'b1;
                    swap_a  = prga_i;
                    swap_va = prga_sj;
                    swap_b  = prga_j;
                    swap_vb = prga_si;
                    i_d     = prga_i;
                    j_d     = prga_j;
                    k_d     = prga_k;
                    ready_d = 1'b1;
                end
            end

            default: begin
                state_d = LOAD_KEY;
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= LOAD_KEY;
            i_q         <= 8'h00;
            j_q         <= 8'h00;
            kc_q        <= '0;
            k_q         <= 8'h00;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            kc_q        <= kc_d;
            k_q         <= k_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
        end
    end

    // Permutation table and key storage: password capture and one swap per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table is reset because the key schedule must start from the identity permutation, so it lives in flops rather than a RAM macro.
            for (int n = 0; n < 256; n++) begin
                s_q[n] <= 8'(n);
            end
            for (int n = 0; n < KEY_LEN; n++) begin
                key_q[n] <= 8'h00;
            end
        end else begin
            if (load_en) begin
                key_q[kc_q] <= bus.password_input;
            end
            // When both addresses coincide both writes carry the same value.
            if (swap_en) begin
                s_q[swap_a] <= swap_va;
                s_q[swap_b] <= swap_vb;
            end
        end
    end

    assign bus.K            = k_q;
    assign bus.output_ready = ready_q;
    assign bus.init_done    = init_done_q;

endmodule

// File: tb/tb_rc4_keystream_gen.sv
// Directed bench for rc4_keystream_gen: three instances with key lengths
// 3 ("Key"), 4 ("Wiki") and 6 ("Secret") checked against published RC4
// keystream bytes and a small software RC4 model.
module tb_rc4_keystream_gen;

    logic clk;
    logic rst_a, rst_b, rst_c;

    rc4_keystream_gen_if if_a ();
    rc4_keystream_gen_if if_b ();
    rc4_keystream_gen_if if_c ();

    rc4_keystream_gen #(.KEY_LEN(3)) u_dut_key (
        .clk (clk),
        .rst (rst_a),
        .bus (if_a)
    );

    rc4_keystream_gen #(.KEY_LEN(4)) u_dut_wiki (
        .clk (clk),
        .rst (rst_b),
        .bus (if_b)
    );

    rc4_keystream_gen #(.KEY_LEN(6)) u_dut_secret (
        .clk (clk),
        .rst (rst_c),
        .bus (if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] key_key    [3] = '{8'h4B, 8'h65, 8'h79};
    logic [7:0] ks_key     [8] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72};
    logic [7:0] wiki_key   [4] = '{8'h57, 8'h69, 8'h6B, 8'h69};
    logic [7:0] ks_wiki    [6] = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
    logic [7:0] secret_key [6] = '{8'h53, 8'h65, 8'h63, 8'h72, 8'h65, 8'h74};
    logic [7:0] ks_secret  [8] = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};
    logic [7:0] model_ks   [300];

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Straight software RC4 over the "Key" password, first 300 bytes.
    task automatic build_model();
        logic [7:0] s [256];
        logic [7:0] i, j, tmp;
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 8'h00;
        for (int n = 0; n < 256; n++) begin
            j    = 8'(j + s[n] + key_key[n % 3]);
            tmp  = s[n];
            s[n] = s[j];
            s[j] = tmp;
        end
        i = 8'h00;
        j = 8'h00;
        for (int k = 0; k < 300; k++) begin
            i           = 8'(i + 8'd1);
            j           = 8'(j + s[i]);
            tmp         = s[i];
            s[i]        = s[j];
            s[j]        = tmp;
            model_ks[k] = s[8'(s[i] + s[j])];
        end
    endtask

    // Loads "Key" on consecutive cycles; key_valid stays high afterwards with
    // a junk byte that the block must ignore. Returns at the negedge after
    // the edge that accepted the last byte.
    task automatic a_load_key();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if_a.password_input = key_key[k];
            if_a.key_valid      = 1'b1;
        end
        @(negedge clk);
        if_a.password_input = 8'hC3;
    endtask

    // Counts edges until init_done rises (bounded) and output_ready pulses seen meanwhile.
    task automatic a_wait_init(output int edges, output int early);
        edges = 0;
        early = 0;
        while (!if_a.init_done && edges < 400) begin
            @(negedge clk);
            edges++;
            if (if_a.output_ready) early++;
        end
    endtask

    initial begin
        int edges;
        int early;
        int nready;

        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        if_a.password_input = 8'h00; if_a.key_valid = 1'b0; if_a.valid = 1'b0;
        if_b.password_input = 8'h00; if_b.key_valid = 1'b0; if_b.valid = 1'b0;
        if_c.password_input = 8'h00; if_c.key_valid = 1'b0; if_c.valid = 1'b0;
        build_model();

        repeat (3) @(negedge clk);
        check("A_rst_K",     16'(if_a.K), 16'h0000);
        check("A_rst_ready", 16'(if_a.output_ready), 16'h0000);
        check("A_rst_init",  16'(if_a.init_done), 16'h0000);
        check("B_rst_K",     16'(if_b.K), 16'h0000);
        check("B_rst_init",  16'(if_b.init_done), 16'h0000);
        check("C_rst_ready", 16'(if_c.output_ready), 16'h0000);

        // "Key" with valid held high throughout loading and scheduling.
        rst_a      = 1'b0;
        if_a.valid = 1'b1;
        a_load_key();
        check("A_init_after_load", 16'(if_a.init_done), 16'h0000);
        a_wait_init(edges, early);
        check("A_ksa_cycles", 16'(edges), 16'd256);
        check("A_no_early_ready", 16'(early), 16'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("A_ready", 16'(if_a.output_ready), 16'h0001);
            check("A_ks", 16'(if_a.K), 16'(ks_key[k]));
        end
        if_a.valid     = 1'b0;
        if_a.key_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("A_idle_ready", 16'(if_a.output_ready), 16'h0000);
            check("A_idle_K_hold", 16'(if_a.K), 16'h0072);
        end

        // Reset in the middle of a stream.
        if_a.valid = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        check("A_stream_rst_K", 16'(if_a.K), 16'h0000);
        check("A_stream_rst_ready", 16'(if_a.output_ready), 16'h0000);
        check("A_stream_rst_init", 16'(if_a.init_done), 16'h0000);
        rst_a      = 1'b0;
        if_a.valid = 1'b0;

        // Reset at KSA iteration 100, then a full reload.
        a_load_key();
        repeat (100) @(negedge clk);
        check("A_midksa_init", 16'(if_a.init_done), 16'h0000);
        rst_a          = 1'b1;
        if_a.key_valid = 1'b0;
        @(negedge clk);
        check("A_ksa_rst_init", 16'(if_a.init_done), 16'h0000);
        rst_a      = 1'b0;
        if_a.valid = 1'b1;
        a_load_key();
        check("A_reload_init", 16'(if_a.init_done), 16'h0000);
        a_wait_init(edges, early);
        check("A_reload_ksa_cycles", 16'(edges), 16'd256);
        check("A_reload_no_early", 16'(early), 16'd0);

        // 300 back-to-back bytes with key_valid noise during PRGA.
        nready = 0;
        for (int k = 0; k < 300; k++) begin
            if_a.key_valid      = 1'($urandom_range(0, 1));
            if_a.password_input = 8'($urandom);
            @(negedge clk);
            if (if_a.output_ready) nready++;
            check("A_stream", 16'(if_a.K), 16'(model_ks[k]));
            if (k < 8) check("A_reload_ks", 16'(if_a.K), 16'(ks_key[k]));
        end
        if_a.valid     = 1'b0;
        if_a.key_valid = 1'b0;
        check("A_stream_ready_count", 16'(nready), 16'd300);
        @(negedge clk);
        check("A_end_ready", 16'(if_a.output_ready), 16'h0000);
        check("A_end_init", 16'(if_a.init_done), 16'h0001);

        // "Wiki" with valid pulsed every third cycle.
        rst_b = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if_b.password_input = wiki_key[k];
            if_b.key_valid      = 1'b1;
            @(negedge clk);
        end
        if_b.key_valid = 1'b0;
        edges = 0;
        while (!if_b.init_done && edges < 400) begin
            @(negedge clk);
            edges++;
        end
        check("B_ksa_cycles", 16'(edges), 16'd256);
        for (int k = 0; k < 6; k++) begin
            if_b.valid = 1'b1;
            @(negedge clk);
            check("B_ready", 16'(if_b.output_ready), 16'h0001);
            check("B_ks", 16'(if_b.K), 16'(ks_wiki[k]));
            if_b.valid = 1'b0;
            @(negedge clk);
            check("B_gap1_ready", 16'(if_b.output_ready), 16'h0000);
            check("B_gap1_K_hold", 16'(if_b.K), 16'(ks_wiki[k]));
            @(negedge clk);
            check("B_gap2_ready", 16'(if_b.output_ready), 16'h0000);
        end

        // "Secret" with valid asserted during loading and scheduling.
        rst_c      = 1'b0;
        if_c.valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            if_c.password_input = secret_key[k];
            if_c.key_valid      = 1'b1;
            @(negedge clk);
            if (if_c.output_ready) early++;
        end
        if_c.key_valid = 1'b0;
        edges = 0;
        early = 0;
        while (!if_c.init_done && edges < 400) begin
            @(negedge clk);
            edges++;
            if (if_c.output_ready) early++;
        end
        check("C_ksa_cycles", 16'(edges), 16'd256);
        check("C_no_early_ready", 16'(early), 16'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("C_ready", 16'(if_c.output_ready), 16'h0001);
            check("C_ks", 16'(if_c.K), 16'(ks_secret[k]));
        end
        if_c.valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
